// File: rtl/gray_pkg.sv
// Shared Gray-code definitions for the 2-bit Gray counter and its step decoder.
package gray_pkg;

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] G1 = 2'b01;
  localparam logic [1:0] G2 = 2'b11;
  localparam logic [1:0] G3 = 2'b10;

  function automatic logic [1:0] gray_next(input logic [1:0] g);
    logic [1:0] r;
    unique case (g)
      G0: r = G1;
      G1: r = G2;
      G2: r = G3;
      G3: r = G0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] gray_prev(input logic [1:0] g);
    logic [1:0] r;
    unique case (g)
      G0: r = G3;
      G1: r = G0;
      G2: r = G1;
      G3: r = G2;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

endpackage

// File: rtl/gray_step_decoder_if.sv
// Control, Gray input and decoded motion outputs of gray_step_decoder.
interface gray_step_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             clr;
  logic [1:0]       gray_in;
  logic [1:0]       bin_out;
  logic             step_fwd;
  logic             step_bwd;
  logic             err;
  logic [WIDTH-1:0] pos;
  logic [WIDTH-1:0] err_cnt;
  logic             locked;

  modport master (
    output en, clr, gray_in,
    input  bin_out, step_fwd, step_bwd, err, pos, err_cnt, locked
  );

  modport slave (
    input  en, clr, gray_in,
    output bin_out, step_fwd, step_bwd, err, pos, err_cnt, locked
  );
endinterface

// File: rtl/gray_sync.sv
// N-stage 2-bit input synchronizer with synchronous reset to 00; N=0 is a wire.
module gray_sync #(
  parameter int unsigned N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] d,
  output logic [1:0] q
);

  if (N == 0) begin : g_pass
    assign q = d;
  end else begin : g_sync
    logic [1:0] stage_q [N];
    logic [1:0] stage_d [N];

    always_comb begin
      stage_d[0] = d;
      for (int unsigned i = 1; i < N; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (rst) stage_q[i] <= '0;
        else     stage_q[i] <= stage_d[i];
      end
    end

    assign q = stage_q[N-1];
  end

endmodule

// File: rtl/gray_step_decoder.sv
// Decodes a 2-bit Gray/quadrature stream into step pulses, a wrapping position
// and a saturating count of illegal two-bit jumps.
module gray_step_decoder
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  gray_step_decoder_if.slave   bus
);

  logic [1:0]       g_s;

  state_t           state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0]       bin_q, bin_d;
  logic             fwd_q, fwd_d;
  logic             bwd_q, bwd_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;

  gray_sync #(.N(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.gray_in),
    .q   (g_s)
  );

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    bin_d     = bin_q;
    fwd_d     = 1'b0;
    bwd_d     = 1'b0;
    err_d     = 1'b0;
    pos_d     = pos_q;
    err_cnt_d = err_cnt_q;
    locked_d  = locked_q;

    if (bus.en) begin
      case (state_q)
        INIT: begin
          // First accepted code only establishes the reference; no event.
          prev_d   = g_s;
          bin_d    = gray2bin(g_s);
          state_d  = TRACK;
          locked_d = 1'b1;
        end
        TRACK: begin
          if (g_s == gray_next(prev_q)) begin
            fwd_d = 1'b1;
            pos_d = pos_q + WIDTH'(1);
          end else if (g_s == gray_prev(prev_q)) begin
            bwd_d = 1'b1;
            pos_d = pos_q - WIDTH'(1);
          end else if (g_s != prev_q) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + WIDTH'(1);
          end
          prev_d = g_s;
          bin_d  = gray2bin(g_s);
        end
      endcase
    end

    // Clear wins over the decode's counter updates but leaves pulses/prev intact.
    if (bus.clr) begin
      pos_d     = '0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      prev_q    <= '0;
      bin_q     <= '0;
      fwd_q     <= 1'b0;
      bwd_q     <= 1'b0;
      err_q     <= 1'b0;
      pos_q     <= '0;
      err_cnt_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      bin_q     <= bin_d;
      fwd_q     <= fwd_d;
      bwd_q     <= bwd_d;
      err_q     <= err_d;
      pos_q     <= pos_d;
      err_cnt_q <= err_cnt_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.step_fwd = fwd_q;
  assign bus.step_bwd = bwd_q;
  assign bus.err      = err_q;
  assign bus.pos      = pos_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.locked   = locked_q;

endmodule

// File: doc/gray_step_decoder.md
Name: gray_step_decoder

Overview:
- Consumes the 2-bit Gray sequence from the Gray counter FSM, or from any 2-bit quadrature-style source, and turns it into motion information.
- Outputs per-step direction pulses, a wrapping position count, the current Gray-to-binary value, and an error flag with a saturating counter for illegal two-bit jumps.
- Sits directly downstream of the Gray counter on the same clock.
- An optional input synchronizer allows the Gray source to be asynchronous.

Parameters:
- WIDTH, 8, width of the position counter and the error counter.
- SYNC_STAGES, 2, number of input synchronizer flops; legal values are 0 to 3, where 0 means gray_in is already synchronous.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample enable; when low, no decode, prev held, outputs hold except pulses, which are 0.
- clr  in  1  synchronous clear of pos and err_cnt.
- gray_in  in  2  Gray code input, forward sequence 00,01,11,10,00.
- bin_out  out  2  binary of the last accepted code: {g1, g1^g0}.
- step_fwd  out  1  one-cycle pulse on a forward step.
- step_bwd  out  1  one-cycle pulse on a backward step.
- err  out  1  one-cycle pulse on an illegal two-bit change.
- pos  out  WIDTH  position count, modulo 2^WIDTH.
- err_cnt  out  WIDTH  illegal-transition count, saturating at 2^WIDTH-1.
- locked  out  1  high once the FSM is in TRACK.

Behaviour:
- Reset, on a synchronous rst: sync flops=00, prev=00, bin_out=00, step_fwd=step_bwd=err=0, pos=0, err_cnt=0, locked=0, state=INIT.
- Synchronizer: gray_in passes through SYNC_STAGES flops to give g_s; with SYNC_STAGES=0, g_s=gray_in. The flops shift every cycle regardless of en.
- FSM has two states, INIT and TRACK.
  - INIT with en=1: prev<=g_s, bin_out<=bin(g_s), go to TRACK, locked<=1. No step or err pulse is generated.
  - INIT with en=0: stay in INIT.
  - TRACK with en=1: compare g_s with prev.
    - Equal: no event.
    - g_s is the forward successor of prev: step_fwd=1, pos<=pos+1, wrapping 2^WIDTH-1 to 0.
    - g_s is the backward predecessor: step_bwd=1, pos<=pos-1, wrapping 0 to 2^WIDTH-1.
    - Both bits differ: err=1, err_cnt<=err_cnt+1 unless already at max, pos unchanged.
    - In all cases prev<=g_s and bin_out<=bin(g_s), so decoding resyncs on the new code.
  - TRACK with en=0: hold everything; pulses are 0.
- Latency: a gray_in value sampled at rising edge t is reflected in the registered outputs after edge t+SYNC_STAGES.
  - With SYNC_STAGES=2, a change seen at edge t gives its pulse in the cycle following edge t+2.
- Pulses last exactly one cycle per event. Back-to-back steps on consecutive cycles give consecutive pulses.
- At most one of step_fwd, step_bwd and err is high in any cycle.
- Priority order is rst > clr > decode.
  - clr=1 forces pos<=0 and err_cnt<=0 in that cycle.
  - Pulses, prev and bin_out still update normally from the decode in the same cycle.
  - clr does not change the FSM state.
- A reset mid-operation returns the block to INIT. The first code accepted after reset is a silent resync: no step, no err.
- Because the sync flops reset to 00, the same value the upstream counter resets to, in-phase resets give no spurious event.

Decomposition:
- Package gray_pkg holds:
  - the state enum {INIT, TRACK};
  - localparams G0=00, G1=01, G2=11, G3=10;
  - functions gray_next(g), gray_prev(g) and gray2bin(g), shared with the upstream counter.
- Sub-module gray_sync, parameterized by N (N=0 is a pass-through), a 2-bit N-stage synchronizer clocked by clk with synchronous reset to 00.

Test Plan (WIDTH=8, SYNC_STAGES=2):
- Reset, en=1, gray_in driven 00,01,11,10,00 held one cycle each:
  - locked=1 after the first en cycle;
  - four step_fwd pulses, each 3 cycles after its input change;
  - pos ends at 4, err_cnt=0, bin_out ends at 00.
- Backward sequence 00,10,11,01,00 from pos=0:
  - four step_bwd pulses;
  - pos steps 255,254,253,252.
- Illegal jumps 00 to 11, then 11 to 00:
  - two err pulses, err_cnt=2, pos unchanged, no step pulses;
  - a following 00 to 01 gives step_fwd.
- Saturation and wrap:
  - 300 illegal jumps give err_cnt=255;
  - 260 forward steps from 0 give pos=4.
- clr coincident with a forward step:
  - that cycle pos=0 and err_cnt=0 while step_fwd=1;
  - the next forward step gives pos=1.
- en low and reset mid-run:
  - en=0 while gray_in advances gives no pulses, and pos and prev hold;
  - assert rst at pos=7 with gray_in=11, then release: pos=0 and locked=0 after reset, the first en cycle resyncs to 11 silently, and a following 10 gives step_fwd with pos=1.
